// File: rtl/fft_frame_scheduler.sv
// Overlapping-frame scheduler: buffers decimated samples in a 2*FRAME_LEN ring and
// streams one FRAME_LEN window per hop to the window/FFT chain. Define FRAME_SCHED_TIMEOUT_EN for the DRAIN watchdog.
module fft_frame_scheduler #(
  parameter int FRAME_LEN      = 1024,
  parameter int HOP            = 512,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid_in,
  output logic [7:0]  frame_data_out,
  output logic        frame_valid_out,
  input  logic        frame_ready_in,
  output logic        frame_last_out,
  input  logic        result_done_in,
  output logic        busy_out,
  output logic [15:0] frame_count_out,
  output logic        overrun_out,
  output logic        timeout_out
);
  localparam int AW = $clog2(2 * FRAME_LEN);
  localparam int CW = $clog2(FRAME_LEN) + 1;
  localparam logic [AW-1:0] FL_A  = AW'(FRAME_LEN);
  localparam logic [CW-1:0] FL_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] HOP_C = CW'(HOP);

  typedef enum logic [1:0] {FILL, WAIT_HOP, STREAM, DRAIN} state_t;
  state_t state;

  logic [7:0]    mem [2*FRAME_LEN];
  logic [AW-1:0] wp, rd_ptr;
  logic [CW-1:0] total, hop_cnt, hop_base, hop_nxt, rd_cnt;
  logic [7:0]    mem_q, skid_data;
  logic          mem_vld, mem_last, skid_vld, skid_last;
  logic          pop, last_hs, issue, start_frame, to_fire;
  logic [1:0]    occ;

  // occ counts beats in flight (RAM output + out reg + skid); reads are only
  // issued while it stays within the two slots that can absorb them.
  assign pop         = frame_valid_out & frame_ready_in;
  assign last_hs     = pop & frame_last_out;
  assign occ         = 2'(frame_valid_out) + 2'(skid_vld) + 2'(mem_vld);
  assign issue       = (state == STREAM) && (rd_cnt != FL_C) && ((occ - 2'(pop)) < 2'd2);
  assign start_frame = (state == WAIT_HOP) && (hop_cnt >= HOP_C);

  always_comb begin
    hop_base = hop_cnt;
    if (state == FILL && total == FL_C) hop_base = HOP_C;
    else if (start_frame)               hop_base = '0;
    hop_nxt = (sample_valid_in && hop_base != FL_C) ? hop_base + CW'(1) : hop_base;
  end

  always_ff @(posedge clk_in) begin
    if (sample_valid_in) mem[wp] <= sample_in;
    if (issue)           mem_q   <= mem[rd_ptr];
  end

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] drain_cnt;

  // a result arriving on the expiry cycle takes precedence over the watchdog
  assign to_fire = (state == DRAIN) && !result_done_in && (drain_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      drain_cnt   <= '0;
      timeout_out <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN && !result_done_in && !to_fire) ? drain_cnt + TW'(1) : '0;
      if (to_fire) timeout_out <= 1'b1;
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_out = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= FILL;
      wp              <= '0;
      rd_ptr          <= '0;
      total           <= '0;
      hop_cnt         <= '0;
      rd_cnt          <= '0;
      mem_vld         <= 1'b0;
      mem_last        <= 1'b0;
      skid_vld        <= 1'b0;
      skid_last       <= 1'b0;
      skid_data       <= '0;
      frame_data_out  <= '0;
      frame_valid_out <= 1'b0;
      frame_last_out  <= 1'b0;
      busy_out        <= 1'b0;
      frame_count_out <= '0;
      overrun_out     <= 1'b0;
    end else begin
      if (sample_valid_in) wp <= wp + AW'(1);
      if (sample_valid_in && total != FL_C) total <= total + CW'(1);
      hop_cnt  <= hop_nxt;
      busy_out <= (state == STREAM) || (state == DRAIN);

      case (state)
        FILL:     if (total == FL_C) state <= WAIT_HOP;
        WAIT_HOP: if (start_frame) state <= STREAM;
        STREAM: begin
          if (hop_cnt == FL_C) overrun_out <= 1'b1;
          if (last_hs) begin
            state           <= DRAIN;
            frame_count_out <= frame_count_out + 16'd1;
          end
        end
        DRAIN:    if (result_done_in || to_fire) state <= WAIT_HOP;
        default:  state <= FILL;
      endcase

      if (start_frame) begin
        rd_ptr <= wp - FL_A;
        rd_cnt <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_cnt <= rd_cnt + CW'(1);
      end
      mem_vld  <= issue;
      mem_last <= issue && (rd_cnt == FL_C - CW'(1));

      // output register refills from skid first, then RAM; a RAM beat that
      // arrives while the output is stalled parks in the skid register
      if (!frame_valid_out || pop) begin
        if (skid_vld) begin
          frame_data_out  <= skid_data;
          frame_last_out  <= skid_last;
          frame_valid_out <= 1'b1;
          skid_vld        <= mem_vld;
          skid_data       <= mem_q;
          skid_last       <= mem_last;
        end else if (mem_vld) begin
          frame_data_out  <= mem_q;
          frame_last_out  <= mem_last;
          frame_valid_out <= 1'b1;
        end else begin
          frame_valid_out <= 1'b0;
          frame_last_out  <= 1'b0;
        end
      end else if (mem_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= mem_q;
        skid_last <= mem_last;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with FRAME_LEN=8, HOP=4, TIMEOUT_CYCLES=16.
module tb_fft_frame_scheduler;
  localparam int FL = 8;

  logic        clk_in = 0, rst_in = 0;
  logic [7:0]  sample_in = 0;
  logic        sample_valid_in = 0, frame_ready_in = 0, result_done_in = 0;
  logic [7:0]  frame_data_out;
  logic        frame_valid_out, frame_last_out, busy_out, overrun_out, timeout_out;
  logic [15:0] frame_count_out;

  always #5 clk_in = ~clk_in;

  fft_frame_scheduler #(.FRAME_LEN(FL), .HOP(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .frame_data_out(frame_data_out), .frame_valid_out(frame_valid_out), .frame_ready_in(frame_ready_in),
    .frame_last_out(frame_last_out), .result_done_in(result_done_in), .busy_out(busy_out),
    .frame_count_out(frame_count_out), .overrun_out(overrun_out), .timeout_out(timeout_out));

  int errs = 0, checks = 0, rmode = 0;
  logic [7:0] beats[$];
  logic       blast[$];
  int         bcyc[$];
  int         cyc = 0, brise = -1, vrise = -1, hold_n = 0, hold_bad = 0;
  logic       v_q = 0, b_q = 0, l_q = 0, stall = 0;
  logic [7:0] d_q = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // beat capture and hold-stability tracking, sampled mid-cycle
  always @(negedge clk_in) begin
    cyc++;
    if (!rst_in) begin
      stall = 0; v_q = 0; b_q = 0;
    end else begin
      if (stall) begin
        hold_n++;
        if (!frame_valid_out || frame_data_out !== d_q || frame_last_out !== l_q) hold_bad++;
      end
      if (busy_out && !b_q) brise = cyc;
      if (frame_valid_out && !v_q) vrise = cyc;
      if (frame_valid_out && frame_ready_in) begin
        beats.push_back(frame_data_out);
        blast.push_back(frame_last_out);
        bcyc.push_back(cyc);
      end
      stall = frame_valid_out && !frame_ready_in;
      d_q = frame_data_out; l_q = frame_last_out; v_q = frame_valid_out; b_q = busy_out;
    end
  end

  task automatic tick(input bit sv, input logic [7:0] d, input bit done);
    @(posedge clk_in); #2;
    sample_valid_in = sv; sample_in = d; result_done_in = done;
    case (rmode)
      0:       frame_ready_in = 1'b1;
      1:       frame_ready_in = 1'b0;
      default: frame_ready_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 8'd0, 0);
  endtask

  task automatic put(input int a, input int b);
    for (int v = a; v <= b; v++) tick(1, 8'(v), 0);
  endtask

  task automatic wait_beats(input int base, input string tag);
    int k = 0;
    while (beats.size() < base + FL && k < 300) begin
      tick(0, 8'd0, 0);
      k++;
    end
    chk(tag, beats.size() >= base + FL, 1);
  endtask

  task automatic chk_frame(input int base, input int first, input string tag);
    for (int i = 0; i < FL; i++) begin
      if (beats.size() > base + i) begin
        chk($sformatf("%s_d%0d", tag, i), beats[base+i], first + i);
        chk($sformatf("%s_l%0d", tag, i), blast[base+i], (i == FL - 1));
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"},  frame_data_out, 0);
    chk({tag, "_valid"}, frame_valid_out, 0);
    chk({tag, "_last"},  frame_last_out, 0);
    chk({tag, "_busy"},  busy_out, 0);
    chk({tag, "_count"}, frame_count_out, 0);
    chk({tag, "_ovr"},   overrun_out, 0);
    chk({tag, "_tmo"},   timeout_out, 0);
  endtask

  initial begin
    int b;
    idle(3);
    chk_reset_outs("rst");
    rst_in = 1;

    // first frame 1..8, back-to-back, first beat one cycle after busy rises
    b = beats.size();
    put(1, 8);
    wait_beats(b, "f1_beats");
    chk_frame(b, 1, "f1");
    if (beats.size() >= b + FL) chk("f1_consec", bcyc[b+FL-1] - bcyc[b], FL - 1);
    chk("f1_lat", vrise - brise, 1);
    idle(2);
    chk("f1_count", frame_count_out, 1);
    chk("f1_busy", busy_out, 1);

    // overlap: second frame is 5..12
    put(9, 12);
    chk("drain_no_beats", beats.size(), b + FL);
    b = beats.size();
    tick(0, 8'd0, 1);
    wait_beats(b, "f2_beats");
    chk_frame(b, 5, "f2");
    idle(2);
    chk("f2_count", frame_count_out, 2);

    // random ready: 9..16 with no loss or duplication
    rmode = 2;
    put(13, 16);
    b = beats.size();
    tick(0, 8'd0, 1);
    wait_beats(b, "f3_beats");
    rmode = 0;
    idle(3);
    chk("f3_exact", beats.size(), b + FL);
    chk_frame(b, 9, "f3");
    chk("f3_count", frame_count_out, 3);

    // backlog: 12 samples in DRAIN, one frame per result
    b = beats.size();
    put(17, 28);
    idle(5);
    chk("bk_no_beats", beats.size(), b);
    chk("bk_busy", busy_out, 1);
    chk("bk_count", frame_count_out, 3);
    chk("bk_ovr", overrun_out, 0);
    tick(0, 8'd0, 1);
    wait_beats(b, "f4_beats");
    chk_frame(b, 21, "f4");
    idle(2);
    chk("f4_count", frame_count_out, 4);
    b = beats.size();
    tick(0, 8'd0, 1);
    idle(20);
    chk("one_per_done", beats.size(), b);
    chk("bk_idle_busy", busy_out, 0);

    // overrun: ready low while a full frame of new samples arrives
    rmode = 1;
    b = beats.size();
    put(29, 40);
    idle(2);
    chk("ovr_flag", overrun_out, 1);
    chk("ovr_busy", busy_out, 1);
    chk("ovr_stalled", beats.size(), b);
    rmode = 0;
    wait_beats(b, "f5_beats");
    chk_frame(b, 25, "f5");
    idle(2);
    chk("f5_count", frame_count_out, 5);

    // asynchronous reset in the middle of a stalled frame
    rmode = 1;
    tick(0, 8'd0, 1);
    idle(4);
    chk("pre_rst_valid", frame_valid_out, 1);
    @(posedge clk_in); #2;
    rst_in = 0;
    #1;
    chk_reset_outs("mid_rst");
    idle(2);
    rst_in = 1;
    rmode = 0;
    b = beats.size();
    put(101, 107);
    idle(10);
    chk("refill_no_beats", beats.size(), b);
    chk("refill_busy", busy_out, 0);
    put(108, 108);
    wait_beats(b, "f6_beats");
    chk_frame(b, 101, "f6");
    idle(2);
    chk("f6_count", frame_count_out, 1);
    chk("f6_ovr", overrun_out, 0);

`ifdef FRAME_SCHED_TIMEOUT_EN
    idle(8);
    chk("tmo_busy_early", busy_out, 1);
    chk("tmo_flag_early", timeout_out, 0);
    idle(20);
    chk("tmo_busy_late", busy_out, 0);
    chk("tmo_flag", timeout_out, 1);
`else
    idle(28);
    chk("drain_wait_busy", busy_out, 1);
    chk("tmo_tied", timeout_out, 0);
`endif

    chk("hold_stable", hold_bad, 0);
    chk("hold_seen", hold_n > 0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Sequences the spectral path: collects decimated audio samples into an overlapping-frame circular buffer and, once enough new samples have arrived, streams one complete frame into the Hanning-window/FFT chain. It then holds off the next frame until the peak finder reports a result. It sits between the last `fir_decimator` stage and `hanning_window`, in the `clk_m` domain. It also exports frame count and overrun/timeout status for debug display.

## Interface
- `FRAME_LEN`, 1024: samples per FFT frame; power of two, ≥ 4.
- `HOP`, 512: new samples required between frame starts; 1 ≤ HOP ≤ FRAME_LEN.
- `TIMEOUT_CYCLES`, 2^20: DRAIN watchdog limit; used only with the macro.
- `clk_in`  in  1  system clock (`clk_m`).
- `rst_in`  in  1  asynchronous, active-low reset.
- `sample_in`  in  8  signed decimated audio sample.
- `sample_valid_in`  in  1  single-cycle strobe qualifying `sample_in`.
- `frame_data_out`  out  8  signed frame sample to the window/FFT.
- `frame_valid_out`  out  1  `frame_data_out` valid.
- `frame_ready_in`  in  1  downstream accepts the beat.
- `frame_last_out`  out  1  high on beat FRAME_LEN-1 of the frame.
- `result_done_in`  in  1  single-cycle strobe from `peak_finder` (`peak_valid_out`).
- `busy_out`  out  1  high in STREAM or DRAIN.
- `frame_count_out`  out  16  frames fully streamed; wraps at 65535→0.
- `overrun_out`  out  1  sticky flag: a window was overwritten before it was fully streamed.
- `timeout_out`  out  1  sticky flag: DRAIN watchdog fired.

## Operation
- Buffer: 2*FRAME_LEN × 8-bit single-clock RAM, 1-cycle read latency.
  - Write pointer `wp` increments on each `sample_valid_in` and wraps at 2*FRAME_LEN.
  - Writes are accepted in every state and are never stalled.
- `total`: count of samples written, saturating at FRAME_LEN.
- `hop_cnt`: samples written since the last frame start, saturating at FRAME_LEN.
- States:
  - FILL (reset state) → WAIT_HOP when `total` reaches FRAME_LEN; `hop_cnt` is forced to HOP on that transition.
  - WAIT_HOP → STREAM when `hop_cnt` ≥ HOP.
    - On entry to STREAM: `start = wp - FRAME_LEN` (mod 2*FRAME_LEN) and `hop_cnt` is cleared. A write in the same cycle is counted after the clear, so `hop_cnt` = 1.
  - STREAM: reads addresses `start` … `start+FRAME_LEN-1` in order. → DRAIN on the handshake of the last beat; `frame_count_out` increments on that cycle.
  - DRAIN → WAIT_HOP on `result_done_in`. `result_done_in` is ignored in every other state.
- Overrun: if `hop_cnt` reaches FRAME_LEN while in STREAM, `overrun_out` sets.
  - The frame still completes with all FRAME_LEN beats.
- Backlog: if `hop_cnt` ≥ 2*HOP on entry to STREAM, only one frame is emitted. The skipped hops are discarded and not queued.

## Timing
- Reset values: `frame_data_out`=0, `frame_valid_out`=0, `frame_last_out`=0, `busy_out`=0, `frame_count_out`=0, `overrun_out`=0, `timeout_out`=0. Reset takes effect immediately on assertion, mid-frame included.
- Output handshake (AXI-stream rules):
  - `frame_valid_out` is not withdrawn and `frame_data_out`/`frame_last_out` stay stable until `frame_ready_in` is high.
  - `frame_valid_out` does not depend combinationally on `frame_ready_in`.
- Latency: first beat valid 2 cycles after STREAM entry (address, then RAM data).
- Throughput: one beat per cycle while `frame_ready_in` is held high. A prefetch/skid register absorbs ready deassertion with no bubble and no duplicated beat.
- `busy_out` is registered and follows the state with 1 cycle of lag.

## Configuration
- `FRAME_SCHED_TIMEOUT_EN` defined:
  - A DRAIN cycle counter runs in DRAIN only.
  - When it hits TIMEOUT_CYCLES, the FSM returns to WAIT_HOP and `timeout_out` sets (sticky).
  - `result_done_in` on the same cycle wins: no timeout flag.
- `FRAME_SCHED_TIMEOUT_EN` undefined:
  - DRAIN waits indefinitely.
  - `timeout_out` is tied to 0 and no counter is built.

## Test plan
- FRAME_LEN=8, HOP=4, ready held 1, samples 1..8 → after sample 8, frame 1..8 streamed on 8 consecutive cycles starting 2 cycles after STREAM entry; `frame_last_out` on value 8; `frame_count_out`=1.
- Continue samples 9..12 and pulse `result_done_in` → second frame is 5..12 (overlap check); `frame_count_out`=2.
- Ready toggled 1,0,0,1 pseudo-randomly during a frame → no lost or duplicated beats; data held stable while ready is low.
- No `result_done_in`, then 12 more samples → at most one frame per `result_done_in`; in DRAIN, samples still written; `overrun_out` stays 0.
- Ready held 0 in STREAM while 8 samples arrive → `overrun_out`=1 and the frame still completes with 8 beats.
- `rst_in` low mid-STREAM → all outputs 0 asynchronously; after release the FSM is in FILL and requires 8 new samples. With the macro and TIMEOUT_CYCLES=16, a DRAIN with no result → WAIT_HOP after 16 cycles, `timeout_out`=1.
